// File: rtl/operand_job_sequencer.sv
// operand_job_sequencer
//   Takes six-operand jobs from a host over valid/ready and queues them in a
//   small FIFO. Each job is issued to a start/done compute core as a one-cycle
//   start pulse, with the operands held stable. The sequencer then waits for
//   done and parks the result in a valid/ready output register.
// Ports
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   job_valid/job_ready      : job input handshake (job_ready = FIFO not full)
//   job_i1..job_i6           : job operands, sampled on accept
//   core_start, core_i1..i6  : start pulse and held operands to the core
//   core_result, core_done   : core completion interface
//   res_valid/res_ready      : result output handshake
//   res_data                 : captured result
//   busy                     : FSM active or jobs still queued
//   timeout_err              : sticky flag for a job abandoned in WAIT
module operand_job_sequencer #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [WIDTH-1:0] job_i1,
    input  logic [WIDTH-1:0] job_i2,
    input  logic [WIDTH-1:0] job_i3,
    input  logic [WIDTH-1:0] job_i4,
    input  logic [WIDTH-1:0] job_i5,
    input  logic [WIDTH-1:0] job_i6,
    output logic             core_start,
    output logic [WIDTH-1:0] core_i1,
    output logic [WIDTH-1:0] core_i2,
    output logic [WIDTH-1:0] core_i3,
    output logic [WIDTH-1:0] core_i4,
    output logic [WIDTH-1:0] core_i5,
    output logic [WIDTH-1:0] core_i6,
    input  logic [WIDTH-1:0] core_result,
    input  logic             core_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy,
    output logic             timeout_err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef logic [5:0][WIDTH-1:0] ops_t;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    // Job FIFO storage and pointers; power-of-two depth lets pointers wrap freely
    ops_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Sequencer registers
    state_t           r_state;
    logic             r_core_start;
    ops_t             r_ops;
    logic [TMR_W-1:0] r_wait_cnt;
    logic             r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic             r_timeout_err;

    // Next-state values
    state_t           w_state_nxt;
    logic             w_start_nxt;
    ops_t             w_ops_nxt;
    logic [TMR_W-1:0] w_wait_cnt_nxt;
    logic             w_res_valid_nxt;
    logic [WIDTH-1:0] w_res_data_nxt;
    logic             w_timeout_err_nxt;

    logic             w_push;
    logic             w_pop;
    ops_t             w_head;

    assign job_ready = (r_count != CNT_W'(DEPTH));
    assign w_push    = job_valid && job_ready;
    assign w_head    = r_mem[r_rd_ptr];

    // FIFO data write (no reset needed on storage)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {job_i6, job_i5, job_i4, job_i3, job_i2, job_i1};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_core_start  <= 1'b0;
            r_ops         <= '0;
            r_wait_cnt    <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_core_start  <= w_start_nxt;
            r_ops         <= w_ops_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_res_valid   <= w_res_valid_nxt;
            r_res_data    <= w_res_data_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    // Next-state logic; start is registered so it is high exactly during ISSUE
    always_comb begin
        w_state_nxt       = r_state;
        w_start_nxt       = 1'b0;
        w_ops_nxt         = r_ops;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_res_valid_nxt   = r_res_valid && !res_ready;
        w_res_data_nxt    = r_res_data;
        w_timeout_err_nxt = r_timeout_err;
        w_pop             = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A result being read this cycle counts as a free register
                if ((r_count != '0) && (!r_res_valid || res_ready)) begin
                    w_pop       = 1'b1;
                    w_ops_nxt   = w_head;
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_wait_cnt_nxt = '0;
                w_state_nxt    = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    w_res_data_nxt  = core_result;
                    w_res_valid_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end else if ((TIMEOUT != 0) && (r_wait_cnt == TMR_W'(TIMEOUT - 1))) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + TMR_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign core_start  = r_core_start;
    assign core_i1     = r_ops[0];
    assign core_i2     = r_ops[1];
    assign core_i3     = r_ops[2];
    assign core_i4     = r_ops[3];
    assign core_i5     = r_ops[4];
    assign core_i6     = r_ops[5];
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign timeout_err = r_timeout_err;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_operand_job_sequencer.sv
// Testbench for operand_job_sequencer: a behavioural core returns the 32-bit
// sum of its operands; expected operands and results are queued on accept
// and checked by monitors when start pulses and result handshakes occur.
module tb_operand_job_sequencer;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         job_valid;
    logic         job_ready;
    logic [W-1:0] job_i1, job_i2, job_i3, job_i4, job_i5, job_i6;
    logic         core_start;
    logic [W-1:0] core_i1, core_i2, core_i3, core_i4, core_i5, core_i6;
    logic [W-1:0] core_result;
    logic         core_done;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         busy;
    logic         timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int starts   = 0;
    int neg_cnt  = 0;
    int last_start = -10;
    int core_mode  = 0;   // 0: done after 5 cycles, 1: never done, 2: done held high
    int c_cnt      = 0;
    logic [W-1:0] c_res;

    logic [191:0] op_q [$];
    logic [W-1:0] res_q [$];

    operand_job_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_i1(job_i1), .job_i2(job_i2), .job_i3(job_i3),
        .job_i4(job_i4), .job_i5(job_i5), .job_i6(job_i6),
        .core_start(core_start),
        .core_i1(core_i1), .core_i2(core_i2), .core_i3(core_i3),
        .core_i4(core_i4), .core_i5(core_i5), .core_i6(core_i6),
        .core_result(core_result), .core_done(core_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural compute core
    assign core_result = c_res;
    always @(posedge clk) begin
        if (rst) begin
            c_cnt     <= 0;
            c_res     <= '0;
            core_done <= 1'b0;
        end else begin
            if (core_start) begin
                c_cnt <= 5;
                c_res <= core_i1 + core_i2 + core_i3 + core_i4 + core_i5 + core_i6;
            end else if (c_cnt != 0) begin
                c_cnt <= c_cnt - 1;
            end
            core_done <= (core_mode == 2) || (core_mode == 0 && c_cnt == 1 && !core_start);
        end
    end

    // Start monitor: operand order, FIFO order, pulse spacing
    always @(negedge clk) begin
        neg_cnt <= neg_cnt + 1;
        if (!rst && core_start) begin
            starts <= starts + 1;
            check("start_gap", 192'((neg_cnt - last_start) >= 3), 192'(1));
            last_start <= neg_cnt;
            if (op_q.size() == 0)
                check("start_unexpected", 192'(core_start), 192'(0));
            else
                check("core_ops", {core_i6, core_i5, core_i4, core_i3, core_i2, core_i1},
                      op_q.pop_front());
        end
    end

    // Result monitor: fires on each result handshake
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (res_q.size() == 0)
                check("res_unexpected", 192'(res_valid), 192'(0));
            else
                check("res_data", 192'(res_data), 192'(res_q.pop_front()));
        end
    end

    task automatic push_job(input logic [W-1:0] a, b, c, d, e, f,
                            input logic [W-1:0] exp, input bit has_res);
        int t;
        t = 0;
        job_i1 = a; job_i2 = b; job_i3 = c; job_i4 = d; job_i5 = e; job_i6 = f;
        job_valid = 1'b1;
        @(negedge clk);
        while (!job_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("push_accept", 192'(job_ready), 192'(1));
        @(posedge clk);
        op_q.push_back({f, e, d, c, b, a});
        if (has_res) res_q.push_back(exp);
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while (!core_start && t < 100) begin
            @(negedge clk);
            t++;
        end
        check(nm, 192'(core_start), 192'(1));
    endtask

    task automatic wait_drain(input string nm);
        int t;
        t = 0;
        @(negedge clk);
        while ((busy || res_valid || op_q.size() != 0 || res_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check(nm, 192'(busy || res_valid), 192'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        bit stable;
        rst = 1'b1; job_valid = 1'b0; res_ready = 1'b1;
        job_i1 = '0; job_i2 = '0; job_i3 = '0; job_i4 = '0; job_i5 = '0; job_i6 = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_start", 192'(core_start), 192'(0));
        check("rst_ops", {core_i6, core_i5, core_i4, core_i3, core_i2, core_i1}, 192'(0));
        check("rst_res_valid", 192'(res_valid), 192'(0));
        check("rst_res_data", 192'(res_data), 192'(0));
        check("rst_busy", 192'(busy), 192'(0));
        check("rst_terr", 192'(timeout_err), 192'(0));
        check("rst_job_ready", 192'(job_ready), 192'(1));
        @(posedge clk); #1;

        // 1: single job, start two cycles after accept, result 15
        s0 = starts;
        push_job(2, 3, 4, 2, 3, 1, 15, 1'b1);
        @(negedge clk);
        check("t1_start_early", 192'(core_start), 192'(0));
        @(negedge clk);
        check("t1_start_lat", 192'(core_start), 192'(1));
        check("t1_busy_active", 192'(busy), 192'(1));
        wait_drain("t1_drain");
        check("t1_busy_after", 192'(busy), 192'(0));
        check("t1_starts", 192'(starts - s0), 192'(1));

        // 2: DEPTH+1 back-to-back jobs, FIFO full after the fifth accept
        @(posedge clk); #1;
        s0 = starts;
        push_job(1, 2, 3, 4, 5, 6, 21, 1'b1);
        push_job(10, 20, 30, 40, 50, 60, 210, 1'b1);
        push_job(7, 7, 7, 7, 7, 7, 42, 1'b1);
        push_job(100, 0, 0, 0, 0, 1, 101, 1'b1);
        push_job(32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0, 1'b1);
        @(negedge clk);
        check("t2_full", 192'(job_ready), 192'(0));
        wait_drain("t2_drain");
        check("t2_starts", 192'(starts - s0), 192'(5));

        // 3: result held while res_ready=0 blocks the next issue
        @(posedge clk); #1;
        res_ready = 1'b0;
        s0 = starts;
        push_job(5, 5, 5, 5, 5, 5, 30, 1'b1);
        push_job(1, 1, 1, 1, 1, 1, 6, 1'b1);
        begin
            int t;
            t = 0;
            while (!res_valid && t < 100) begin
                @(negedge clk);
                t++;
            end
        end
        check("t3_res_valid", 192'(res_valid), 192'(1));
        stable = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (!res_valid || res_data !== 32'd30) stable = 1'b0;
        end
        check("t3_res_stable", 192'(stable), 192'(1));
        check("t3_start_withheld", 192'(starts - s0), 192'(1));
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_drain("t3_drain");
        check("t3_starts", 192'(starts - s0), 192'(2));

        // 6: done held high across ISSUE, captured on first WAIT cycle
        @(posedge clk); #1;
        core_mode = 2;
        push_job(9, 8, 7, 6, 5, 4, 39, 1'b1);
        wait_start("t6_start");
        @(negedge clk);
        check("t6_not_in_issue", 192'(res_valid), 192'(0));
        @(negedge clk);
        check("t6_first_wait", 192'(res_valid), 192'(1));
        @(posedge clk); #1;
        core_mode = 0;
        wait_drain("t6_drain");

        // 4: core never finishes, timeout after 8 WAIT cycles
        @(posedge clk); #1;
        core_mode = 1;
        push_job(3, 3, 3, 3, 3, 3, 0, 1'b0);
        wait_start("t4_start");
        repeat (8) @(negedge clk);
        check("t4_terr_early", 192'(timeout_err), 192'(0));
        @(negedge clk);
        check("t4_terr_set", 192'(timeout_err), 192'(1));
        check("t4_no_result", 192'(res_valid), 192'(0));
        @(posedge clk); #1;
        core_mode = 0;
        push_job(2, 2, 2, 2, 2, 2, 12, 1'b1);
        wait_drain("t4_drain");
        check("t4_terr_sticky", 192'(timeout_err), 192'(1));

        // 5: reset during WAIT with two jobs queued
        @(posedge clk); #1;
        push_job(1, 0, 0, 0, 0, 0, 1, 1'b1);
        push_job(2, 0, 0, 0, 0, 0, 2, 1'b1);
        push_job(3, 0, 0, 0, 0, 0, 3, 1'b1);
        check("t5_busy_pre", 192'(busy), 192'(1));
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        op_q.delete();
        res_q.delete();
        s0 = starts;
        @(negedge clk);
        check("t5_start", 192'(core_start), 192'(0));
        check("t5_ops", {core_i6, core_i5, core_i4, core_i3, core_i2, core_i1}, 192'(0));
        check("t5_res_valid", 192'(res_valid), 192'(0));
        check("t5_res_data", 192'(res_data), 192'(0));
        check("t5_busy", 192'(busy), 192'(0));
        check("t5_terr", 192'(timeout_err), 192'(0));
        check("t5_job_ready", 192'(job_ready), 192'(1));
        repeat (20) @(negedge clk);
        check("t5_no_start", 192'(starts - s0), 192'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
